anim_sequencer: RTL and testbench
=================================

# anim_sequencer

Parametrised successor to the single-bucket animation frame stepper for the rotating 3D display. It measures the rotation period from the `clock_cycle` index input and divides it into `FB_SIZE` equal frame slots. Each slot is stepped on time, and `frame_num` is re-phased to 0 on every rotation edge. It also walks through `NUM_FB` frame buckets when `clock_next_fb` requests it. The outputs feed the frame reader as a flat frame address.

## Interface
Parameters:
- `CNT_WIDTH`, 26: width of the period counter, period register and per-frame divisor.
- `FB_SIZE`, 32: frames per bucket; must be at least 2.
- `NUM_FB`, 8: number of frame buckets; must be at least 1.
- `FIDX_W`, 8: width of `frame_num`; must satisfy 2^FIDX_W ≥ FB_SIZE.
- `FB_W`, 8: width of `fb_num`; must satisfy 2^FB_W ≥ NUM_FB.
- `DEFAULT_CPF`, 10000: clocks per frame used before the first measurement completes.

Ports (one clock; reset is synchronous, active-high):
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clock_cycle` in 1: rotation index level, synchronous to `clock`; the rising edge marks the start of a rotation.
- `clock_next_fb` in 1: one-cycle request to advance the bucket.
- `loop_en` in 1: 1 = wrap the bucket index at the end; 0 = hold on the last bucket.
- `frame_num` out FIDX_W: frame index within the bucket.
- `fb_num` out FB_W: current bucket.
- `frame_addr` out FIDX_W+FB_W: fb_num*FB_SIZE + frame_num, combinational from the registers.
- `frame_stb` out 1: one-cycle pulse in the first cycle a new `frame_num` is visible.
- `period_valid` out 1: a measured period is in use.
- `overflow` out 1: sticky flag; the period counter saturated.

## Operation
- Edge detect:
  - `cyc_prev` is a register, reset to 0.
  - edge = `clock_cycle` & ~`cyc_prev`.
- Period counter `pcnt`:
  - Set to 1 on an edge.
  - Otherwise increments, saturating at all-ones.
  - With edges P clocks apart, `pcnt` reads P at the second edge.
- Arming:
  - The first edge after reset only arms the block.
  - Each later edge loads `period <= pcnt` and starts the divider.
  - If `pcnt` is saturated at that edge, the period is not loaded, the divider is not started, and `overflow` is set. `overflow` clears only on reset.
- Divider:
  - Computes `cpf = period / FB_SIZE`, with the result clamped to at least 1.
  - On done, loads `cpf` and sets `period_valid`.
  - A start while busy restarts the divider with the new period; the latest period wins.
  - The old `cpf` stays in use until done.
- Frame stepping:
  - `fcnt` counts clocks within the current frame.
  - When `fcnt == cpf-1`: `fcnt <= 0`, `frame_num` advances (wrapping from FB_SIZE-1 to 0), and `frame_stb` is set.
- Re-phase: on every edge, including the arming edge, `fcnt <= 0`, `frame_num <= 0` and `frame_stb <= 1`. An edge has priority over a step in the same cycle.
- Buckets:
  - `clock_next_fb` sets `fb_pend`.
  - At the next edge, if `fb_pend` is set (or `clock_next_fb` is high in the edge cycle itself), `fb_num` advances and `fb_pend` clears.
  - At `fb_num == NUM_FB-1`: wraps to 0 if `loop_en`, otherwise holds.
  - Multiple requests between two edges count as one.

## Timing
- Reset values:
  - `frame_num` = 0, `fb_num` = 0, `frame_stb` = 0, `period_valid` = 0, `overflow` = 0.
  - `cpf` = DEFAULT_CPF, `pcnt` = 0, `fb_pend` = 0, divider idle.
- Reset asserted mid-operation aborts the divider; everything returns to the reset values on the next clock edge.
- Edge to `frame_num` = 0: 1 clock (registered).
- Divider latency: done exactly CNT_WIDTH+1 clocks after start; new `cpf` is used from the next cycle.
- Frame period: exactly `cpf` clocks between successive `frame_stb` pulses, absent an edge.
- `frame_stb` and `frame_num` update in the same cycle.
- Bucket change becomes visible in the same cycle as the re-phase to `frame_num` = 0.
- If the rotation is shorter than FB_SIZE*cpf, the last frames are truncated by the re-phase.
- If the rotation is longer, `frame_num` wraps and continues until the edge.

## Structure
- Shared include/package `anim_params`: defaults for CNT_WIDTH, FB_SIZE, NUM_FB, DEFAULT_CPF, and the clamp constant 1.
- Sub-module `seq_divider`:
  - Restoring shift-subtract, one quotient bit per clock, parametrised by WIDTH.
  - Ports: `clock`, `reset`, `start`, `dividend`, `divisor`, `busy`, `done`, `quotient`.
  - Replaces the current single-cycle divider.
- Top level holds the edge detect, period counter, frame stepper and bucket register; target 120–400 lines of RTL total.

## Test plan
All scenarios use CNT_WIDTH=16, FB_SIZE=4, NUM_FB=3, DEFAULT_CPF=50.
- Reset, then no edges → `frame_stb` every 50 clocks; `frame_num` runs 0,1,2,3,0; `period_valid` = 0.
- Edges every 400 clocks → at the second edge `period` = 400; 17 clocks later `cpf` = 100 and `period_valid` = 1; `frame_num` then steps every 100 clocks and reads 0 one clock after each edge.
- Period changes to 240 mid-stream → `cpf` = 60 after the divider; an edge arriving at `fcnt` = 30 forces `frame_num` = 0 with `frame_stb` pulsed.
- `clock_next_fb` pulsed twice between edges, `loop_en` = 1 → `fb_num` increments by 1 at the next edge only. Repeat to `fb_num` = 2, then next request → 0. With `loop_en` = 0 → holds at 2. `frame_addr` = 8 + frame_num.
- `clock_cycle` held low for more than 65535 clocks → `overflow` = 1, `period` unchanged, old `cpf` kept; `reset` clears `overflow`.
- Edge coincident with a `clock_next_fb` pulse, and reset asserted during a divider run → the bucket advances at that edge; reset returns all outputs to reset values one clock later and `done` never fires.

Source files
------------

// File: rtl/anim_params.sv
// Shared defaults and types for the animation frame sequencer and its divider.
package anim_params;

    localparam int DEF_CNT_WIDTH = 26;
    localparam int DEF_FB_SIZE   = 32;
    localparam int DEF_NUM_FB    = 8;
    localparam int DEF_CPF       = 10000;
    localparam int CPF_MIN       = 1;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider producing one quotient bit per clock.
// done pulses WIDTH+1 clocks after start; a new start always restarts the run.
module seq_divider
    import anim_params::*;
#(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic [WIDTH-1:0] quo, quo_next;
    logic [WIDTH-1:0] dsr, dsr_next;
    logic [CW-1:0]    count, count_next;
    logic             done_next;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DIV_IDLE;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            quo   <= quo_next;
            dsr   <= dsr_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    // The dividend is shifted out of quo MSB-first while quotient bits shift in.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        quo_next   = quo;
        dsr_next   = dsr;
        count_next = count;
        done_next  = 1'b0;
        shifted    = {rem, quo[WIDTH-1]};
        trial      = shifted - {1'b0, dsr};

        if (start) begin
            state_next = DIV_RUN;
            rem_next   = '0;
            quo_next   = dividend;
            dsr_next   = divisor;
            count_next = CW'(WIDTH);
        end else if (state == DIV_RUN) begin
            rem_next   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_next   = {quo[WIDTH-2:0], ~trial[WIDTH]};
            count_next = count - CW'(1);
            if (count == CW'(1)) begin
                state_next = DIV_IDLE;
                done_next  = 1'b1;
            end
        end
    end

    assign busy     = (state == DIV_RUN);
    assign quotient = quo;

endmodule

// File: rtl/anim_sequencer.sv
// Rotation-locked animation frame sequencer: measures the rotation period,
// splits it into FB_SIZE frame slots and walks through NUM_FB frame buckets.
module anim_sequencer
    import anim_params::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int FB_SIZE     = DEF_FB_SIZE,
    parameter int NUM_FB      = DEF_NUM_FB,
    parameter int FIDX_W      = 8,
    parameter int FB_W        = 8,
    parameter int DEFAULT_CPF = DEF_CPF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_cycle,
    input  logic                     clock_next_fb,
    input  logic                     loop_en,
    output logic [FIDX_W-1:0]        frame_num,
    output logic [FB_W-1:0]          fb_num,
    output logic [FIDX_W+FB_W-1:0]   frame_addr,
    output logic                     frame_stb,
    output logic                     period_valid,
    output logic                     overflow
);

    localparam int ADDR_W = FIDX_W + FB_W;

    logic                 cyc_prev;
    logic                 cyc_edge;
    logic                 armed;
    logic                 pcnt_sat;
    logic                 div_start;
    logic                 div_busy;
    logic                 div_done;
    logic                 fb_pend;
    logic [CNT_WIDTH-1:0] pcnt;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] period_next;
    logic [CNT_WIDTH-1:0] quotient;
    logic [CNT_WIDTH-1:0] cpf;
    logic [CNT_WIDTH-1:0] fcnt;

    assign cyc_edge    = clock_cycle & ~cyc_prev;
    assign pcnt_sat    = &pcnt;
    assign div_start   = cyc_edge & armed & ~pcnt_sat;
    assign period_next = div_start ? pcnt : period;

    // A saturated count means the rotation was too slow to measure; keep the old period.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_prev <= 1'b0;
            pcnt     <= '0;
            armed    <= 1'b0;
            period   <= '0;
            overflow <= 1'b0;
        end else begin
            cyc_prev <= clock_cycle;
            period   <= period_next;
            if (cyc_edge) begin
                pcnt  <= CNT_WIDTH'(1);
                armed <= 1'b1;
                if (armed && pcnt_sat) begin
                    overflow <= 1'b1;
                end
            end else if (!pcnt_sat) begin
                pcnt <= pcnt + CNT_WIDTH'(1);
            end
        end
    end

    seq_divider #(
        .WIDTH (CNT_WIDTH)
    ) u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (period_next),
        .divisor  (CNT_WIDTH'(FB_SIZE)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cpf          <= CNT_WIDTH'(DEFAULT_CPF);
            period_valid <= 1'b0;
        end else if (div_done && !div_busy) begin
            cpf          <= (quotient < CNT_WIDTH'(CPF_MIN)) ? CNT_WIDTH'(CPF_MIN) : quotient;
            period_valid <= 1'b1;
        end
    end

    // The >= keeps stepping sane if cpf shrinks below the running frame count.
    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt      <= '0;
            frame_num <= '0;
            frame_stb <= 1'b0;
        end else if (cyc_edge) begin
            fcnt      <= '0;
            frame_num <= '0;
            frame_stb <= 1'b1;
        end else if (fcnt >= cpf - CNT_WIDTH'(1)) begin
            fcnt      <= '0;
            frame_num <= (frame_num == FIDX_W'(FB_SIZE - 1)) ? '0 : frame_num + FIDX_W'(1);
            frame_stb <= 1'b1;
        end else begin
            fcnt      <= fcnt + CNT_WIDTH'(1);
            frame_stb <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fb_num  <= '0;
            fb_pend <= 1'b0;
        end else if (cyc_edge) begin
            if (fb_pend || clock_next_fb) begin
                if (fb_num == FB_W'(NUM_FB - 1)) begin
                    if (loop_en) begin
                        fb_num <= '0;
                    end
                end else begin
                    fb_num <= fb_num + FB_W'(1);
                end
            end
            fb_pend <= 1'b0;
        end else if (clock_next_fb) begin
            fb_pend <= 1'b1;
        end
    end

    assign frame_addr = ADDR_W'(fb_num) * ADDR_W'(FB_SIZE) + ADDR_W'(frame_num);

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: an event-time reference model predicts
// every frame strobe and status rise; a negedge monitor compares against the DUT.
module tb_anim_sequencer;

    localparam int CNT_WIDTH   = 16;
    localparam int FB_SIZE     = 4;
    localparam int NUM_FB      = 3;
    localparam int FIDX_W      = 8;
    localparam int FB_W        = 8;
    localparam int DEFAULT_CPF = 50;
    localparam int DIV_LAT     = CNT_WIDTH + 2;
    localparam int SAT         = (1 << CNT_WIDTH) - 1;

    logic clock         = 1'b0;
    logic reset         = 1'b1;
    logic clock_cycle   = 1'b0;
    logic clock_next_fb = 1'b0;
    logic loop_en       = 1'b1;
    logic [FIDX_W-1:0]      frame_num;
    logic [FB_W-1:0]        fb_num;
    logic [FIDX_W+FB_W-1:0] frame_addr;
    logic frame_stb;
    logic period_valid;
    logic overflow;

    anim_sequencer #(
        .CNT_WIDTH   (CNT_WIDTH),
        .FB_SIZE     (FB_SIZE),
        .NUM_FB      (NUM_FB),
        .FIDX_W      (FIDX_W),
        .FB_W        (FB_W),
        .DEFAULT_CPF (DEFAULT_CPF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clock_cycle   (clock_cycle),
        .clock_next_fb (clock_next_fb),
        .loop_en       (loop_en),
        .frame_num     (frame_num),
        .fb_num        (fb_num),
        .frame_addr    (frame_addr),
        .frame_stb     (frame_stb),
        .period_valid  (period_valid),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int t;
        int frame;
        int fb;
        bit pv;
        bit ovf;
    } stb_exp_t;

    stb_exp_t stb_q[$];
    int       pv_q[$];
    int       ovf_q[$];

    int total = 0;
    int bad   = 0;
    int tcyc  = 0;

    int m_cpf, m_pend_cpf, m_pend_t, m_last_stb, m_last_edge, m_frame, m_fb;
    bit m_prev, m_armed, m_pend_v, m_pv, m_ovf, m_fbreq;

    // Reference model: inputs of cycle c decide what becomes visible in cycle c+1.
    task automatic model_step(input int c, input logic rst, input logic cc,
                              input logic nfb, input logic le);
        bit cyc_edge;
        bit stb;
        int p;
        if (rst) begin
            m_prev = 0; m_armed = 0; m_pend_v = 0; m_pv = 0; m_ovf = 0; m_fbreq = 0;
            m_cpf = DEFAULT_CPF; m_fb = 0; m_frame = 0; m_last_stb = c + 1;
            return;
        end
        cyc_edge = cc && !m_prev;
        m_prev   = cc;
        stb      = 0;
        if (cyc_edge) begin
            if (m_armed) begin
                p = c - m_last_edge;
                if (p >= SAT) begin
                    if (!m_ovf) ovf_q.push_back(c + 1);
                    m_ovf = 1;
                end else begin
                    m_pend_v   = 1;
                    m_pend_t   = c + DIV_LAT;
                    m_pend_cpf = (p / FB_SIZE < 1) ? 1 : p / FB_SIZE;
                end
            end
            m_armed     = 1;
            m_last_edge = c;
            if (m_fbreq || nfb)
                m_fb = (m_fb == NUM_FB - 1) ? (le ? 0 : m_fb) : m_fb + 1;
            m_fbreq = 0;
            m_frame = 0;
            stb     = 1;
        end else begin
            if (nfb) m_fbreq = 1;
            if (c - m_last_stb >= m_cpf - 1) begin
                m_frame = (m_frame + 1) % FB_SIZE;
                stb     = 1;
            end
        end
        if (m_pend_v && m_pend_t == c + 1) begin
            if (!m_pv) pv_q.push_back(c + 1);
            m_pv     = 1;
            m_cpf    = m_pend_cpf;
            m_pend_v = 0;
        end
        if (stb) begin
            m_last_stb = c + 1;
            stb_q.push_back('{c + 1, m_frame, m_fb, m_pv, m_ovf});
        end
    endtask

    bit       mon_prev_pv  = 0;
    bit       mon_prev_ovf = 0;
    stb_exp_t mon_e;
    logic [FIDX_W-1:0]      exp_frame;
    logic [FB_W-1:0]        exp_fb;
    logic [FIDX_W+FB_W-1:0] exp_addr;

    always @(negedge clock) begin
        tcyc++;
        while (stb_q.size() > 0 && stb_q[0].t < tcyc) begin
            total++; bad++;
            $display("[TB] FAIL stb_missing: no frame_stb seen, required at cycle %0d (frame %0d)",
                     stb_q[0].t, stb_q[0].frame);
            stb_q.delete(0);
        end
        while (pv_q.size() > 0 && pv_q[0] < tcyc) begin
            total++; bad++;
            $display("[TB] FAIL pv_rise_missing: period_valid still low, required high at cycle %0d", pv_q[0]);
            pv_q.delete(0);
        end
        while (ovf_q.size() > 0 && ovf_q[0] < tcyc) begin
            total++; bad++;
            $display("[TB] FAIL ovf_rise_missing: overflow still low, required high at cycle %0d", ovf_q[0]);
            ovf_q.delete(0);
        end

        if (frame_stb === 1'b1) begin
            total++;
            if (stb_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL stb_unexpected: frame_stb at cycle %0d frame_num=%0d, required none",
                         tcyc, frame_num);
            end else begin
                mon_e     = stb_q.pop_front();
                exp_frame = FIDX_W'(mon_e.frame);
                exp_fb    = FB_W'(mon_e.fb);
                exp_addr  = (FIDX_W+FB_W)'(mon_e.fb * FB_SIZE + mon_e.frame);
                if (mon_e.t != tcyc || frame_num !== exp_frame || fb_num !== exp_fb ||
                    frame_addr !== exp_addr || period_valid !== mon_e.pv || overflow !== mon_e.ovf) begin
                    bad++;
                    $display("[TB] FAIL stb_event: got cyc=%0d frame=%0d fb=%0d addr=%0d pv=%0b ovf=%0b, required cyc=%0d frame=%0d fb=%0d addr=%0d pv=%0b ovf=%0b",
                             tcyc, frame_num, fb_num, frame_addr, period_valid, overflow,
                             mon_e.t, exp_frame, exp_fb, exp_addr, mon_e.pv, mon_e.ovf);
                end
            end
        end

        if (period_valid === 1'b1 && !mon_prev_pv) begin
            total++;
            if (pv_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL pv_rise: period_valid rose at cycle %0d, required no rise", tcyc);
            end else if (pv_q[0] != tcyc) begin
                bad++;
                $display("[TB] FAIL pv_rise: period_valid rose at cycle %0d, required cycle %0d", tcyc, pv_q[0]);
                pv_q.delete(0);
            end else begin
                pv_q.delete(0);
            end
        end
        if (overflow === 1'b1 && !mon_prev_ovf) begin
            total++;
            if (ovf_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL ovf_rise: overflow rose at cycle %0d, required no rise", tcyc);
            end else if (ovf_q[0] != tcyc) begin
                bad++;
                $display("[TB] FAIL ovf_rise: overflow rose at cycle %0d, required cycle %0d", tcyc, ovf_q[0]);
                ovf_q.delete(0);
            end else begin
                ovf_q.delete(0);
            end
        end
        mon_prev_pv  = (period_valid === 1'b1);
        mon_prev_ovf = (overflow === 1'b1);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic rst, input logic cc, input logic nfb, input logic le);
        reset         = rst;
        clock_cycle   = cc;
        clock_next_fb = nfb;
        loop_en       = le;
        model_step(tcyc, rst, cc, nfb, le);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        end
        tick();
        check_output("reset_frame_num", 32'(frame_num), 32'd0);
        check_output("reset_fb_num", 32'(fb_num), 32'd0);
        check_output("reset_frame_addr", 32'(frame_addr), 32'd0);
        check_output("reset_frame_stb", 32'(frame_stb), 32'd0);
        check_output("reset_period_valid", 32'(period_valid), 32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_cycles(input int n, input logic cc, input logic le);
        for (int i = 0; i < n; i++) begin
            tick();
            apply_stimulus(1'b0, cc, 1'b0, le);
        end
    endtask

    // One rotation: clock_cycle high for hi_w clocks, then low; optional bucket requests.
    task automatic rotation(input int period, input int hi_w, input int nfb_n,
                            input bit nfb_at_edge, input logic le);
        logic nfb;
        for (int i = 0; i < period; i++) begin
            nfb = (nfb_at_edge && i == 0) || (nfb_n >= 1 && i == period / 3) ||
                  (nfb_n >= 2 && i == period / 2);
            tick();
            apply_stimulus(1'b0, i < hi_w, nfb, le);
        end
    endtask

    initial begin
        do_reset(3);
        run_cycles(260, 1'b0, 1'b1);

        repeat (5) rotation(400, 20, 0, 0, 1'b1);
        repeat (4) rotation(240, 10, 0, 0, 1'b1);
        repeat (3) rotation(270, 10, 0, 0, 1'b1);
        repeat (4) rotation(300, 15, 2, 0, 1'b1);
        repeat (3) rotation(300, 15, 1, 0, 1'b0);
        rotation(300, 15, 0, 1, 1'b1);
        rotation(300, 15, 0, 1, 1'b1);

        for (int k = 0; k < 40; k++) begin
            rotation(int'($urandom_range(30, 600)), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
                     logic'($urandom_range(0, 1)));
        end

        run_cycles(66000, 1'b0, 1'b1);
        repeat (3) rotation(200, 10, 0, 0, 1'b1);

        repeat (2) rotation(400, 20, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            apply_stimulus(1'b0, i < 3, 1'b0, 1'b1);
        end
        do_reset(1);
        run_cycles(180, 1'b0, 1'b1);
        tick();

        while (stb_q.size() > 0 && stb_q[0].t <= tcyc) begin
            total++; bad++;
            $display("[TB] FAIL stb_missing_end: no frame_stb seen, required at cycle %0d", stb_q[0].t);
            stb_q.delete(0);
        end
        while (pv_q.size() > 0 && pv_q[0] <= tcyc) begin
            total++; bad++;
            $display("[TB] FAIL pv_rise_missing_end: required at cycle %0d", pv_q[0]);
            pv_q.delete(0);
        end
        while (ovf_q.size() > 0 && ovf_q[0] <= tcyc) begin
            total++; bad++;
            $display("[TB] FAIL ovf_rise_missing_end: required at cycle %0d", ovf_q[0]);
            ovf_q.delete(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
